byte_ram_lsu: RTL and testbench

Load/store sequencer directly upstream of the byte-wide dual-port data RAM (1024 x 8, async read, sync write per port).
- Accepts one 32-bit load or store request at a time from the core.
- Splits the request into byte accesses, using both RAM ports per cycle.
- Returns a sign- or zero-extended load result, or an error for misaligned or illegal accesses.
- Little-endian throughout.

---
 rtl/byte_ram_lsu.sv | 150 +++++++++++++++
 tb/tb_byte_ram_lsu.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/byte_ram_lsu.sv
// byte_ram_lsu: load/store sequencer driving a byte-wide dual-port RAM, two bytes per beat.
// Optional LSU_RANGE_CHECK_EN flags requests whose address bits above ADDR_W are nonzero.
module byte_ram_lsu #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] addr_a,
  output logic [7:0]        data_in_a,
  output logic              we_a,
  input  logic [7:0]        data_out_a,
  output logic [ADDR_W-1:0] addr_b,
  output logic [7:0]        data_in_b,
  output logic              we_b,
  input  logic [7:0]        data_out_b
);
  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_e;
  state_e state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, addr_a_q, addr_a_d, addr_b_q, addr_b_d;
  logic [15:0] wdata_hi_q, wdata_hi_d, asm_q, asm_d;
  logic [31:0] rdata_q, rdata_d, ext;
  logic [2:0] funct3_q, funct3_d;
  logic [7:0] din_a_q, din_a_d, din_b_q, din_b_d;
  logic we_q, we_d, err_q, err_d, we_a_q, we_a_d, we_b_q, we_b_d;
  logic illegal, misaligned, range_err, req_byte;
  logic [15:0] beat_data;
  assign req_byte   = req_funct3[1:0] == 2'b00;
  assign illegal    = req_funct3[1:0] == 2'b11 || req_funct3[2:1] == 2'b11 || (req_we && req_funct3[2]);
  assign misaligned = (req_funct3[1:0] == 2'b01 && req_addr[0]) || (req_funct3[1:0] == 2'b10 && |req_addr[1:0]);
`ifdef LSU_RANGE_CHECK_EN
  assign range_err = |req_addr[31:ADDR_W];
`else
  logic unused_hi;
  assign unused_hi = ^req_addr[31:ADDR_W];
  assign range_err = 1'b0;
`endif
  assign beat_data = {data_out_b, data_out_a};
  // funct3[0] selects halfword, funct3[2] selects zero-extension
  assign ext = funct3_q[0]
    ? {funct3_q[2] ? 16'h0 : {16{beat_data[15]}}, beat_data}
    : {funct3_q[2] ? 24'h0 : {24{beat_data[7]}}, beat_data[7:0]};
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_hi_d = wdata_hi_q;
    funct3_d   = funct3_q;
    we_d       = we_q;
    asm_d      = asm_q;
    addr_a_d   = addr_a_q;
    addr_b_d   = addr_b_q;
    din_a_d    = din_a_q;
    din_b_d    = din_b_q;
    we_a_d     = 1'b0;
    we_b_d     = 1'b0;
    err_d      = 1'b0;
    rdata_d    = '0;
    unique case (state_q)
      IDLE: if (req_valid) begin
        addr_d     = req_addr[ADDR_W-1:0];
        wdata_hi_d = req_wdata[31:16];
        funct3_d   = req_funct3;
        we_d       = req_we;
        if (illegal || misaligned || range_err) begin
          state_d = RESP;
          err_d   = 1'b1;
        end else begin
          state_d  = BEAT0;
          addr_a_d = req_addr[ADDR_W-1:0];
          addr_b_d = req_byte ? addr_b_q : req_addr[ADDR_W-1:0] + ADDR_W'(1);
          din_a_d  = req_wdata[7:0];
          din_b_d  = req_byte ? din_b_q : req_wdata[15:8];
          we_a_d   = req_we;
          we_b_d   = req_we && !req_byte;
        end
      end
      BEAT0: begin
        asm_d = beat_data;
        if (funct3_q[1]) begin
          state_d  = BEAT1;
          addr_a_d = addr_q + ADDR_W'(2);
          addr_b_d = addr_q + ADDR_W'(3);
          din_a_d  = wdata_hi_q[7:0];
          din_b_d  = wdata_hi_q[15:8];
          we_a_d   = we_q;
          we_b_d   = we_q;
        end else begin
          state_d = RESP;
          rdata_d = we_q ? '0 : ext;
        end
      end
      BEAT1: begin
        state_d = RESP;
        rdata_d = we_q ? '0 : {beat_data, asm_q};
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_hi_q <= '0;
      funct3_q   <= '0;
      we_q       <= 1'b0;
      asm_q      <= '0;
      addr_a_q   <= '0;
      addr_b_q   <= '0;
      din_a_q    <= '0;
      din_b_q    <= '0;
      we_a_q     <= 1'b0;
      we_b_q     <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_hi_q <= wdata_hi_d;
      funct3_q   <= funct3_d;
      we_q       <= we_d;
      asm_q      <= asm_d;
      addr_a_q   <= addr_a_d;
      addr_b_q   <= addr_b_d;
      din_a_q    <= din_a_d;
      din_b_q    <= din_b_d;
      we_a_q     <= we_a_d;
      we_b_q     <= we_b_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
    end
  end
  assign req_ready  = state_q == IDLE;
  assign resp_valid = state_q == RESP;
  assign resp_err   = err_q;
  assign resp_rdata = rdata_q;
  assign addr_a     = addr_a_q;
  assign addr_b     = addr_b_q;
  assign data_in_a  = din_a_q;
  assign data_in_b  = din_b_q;
  assign we_a       = we_a_q;
  assign we_b       = we_b_q;
endmodule

// File: tb/tb_byte_ram_lsu.sv
// tb_byte_ram_lsu: drives byte_ram_lsu against a behavioural RAM and a byte-array reference model.
module tb_byte_ram_lsu;
  logic clk = 1'b0;
  logic rst;
  logic req_valid, req_ready, req_we, resp_valid, resp_err, we_a, we_b;
  logic [2:0] req_funct3;
  logic [31:0] req_addr, req_wdata, resp_rdata;
  logic [9:0] addr_a, addr_b;
  logic [7:0] data_in_a, data_in_b, data_out_a, data_out_b;
  logic [7:0] ram [1024];
  logic [7:0] ref_mem [1024];
  logic pl_en = 1'b0;
  logic [9:0] pl_addr;
  logic [7:0] pl_data;
  int passed = 0;
  int total = 0;

  always #5 clk = ~clk;

  byte_ram_lsu #(.ADDR_W(10)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .addr_a(addr_a), .data_in_a(data_in_a), .we_a(we_a), .data_out_a(data_out_a),
    .addr_b(addr_b), .data_in_b(data_in_b), .we_b(we_b), .data_out_b(data_out_b)
  );

  always @(posedge clk) begin
    if (pl_en) ram[pl_addr] <= pl_data;
    if (we_a) ram[addr_a] <= data_in_a;
    if (we_b) ram[addr_b] <= data_in_b;
  end
  assign data_out_a = ram[addr_a];
  assign data_out_b = ram[addr_b];

  function automatic int m_size(input logic [2:0] f3);
    return (f3 == 3'd2) ? 4 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 1;
  endfunction

  function automatic logic m_err(input logic w, input logic [2:0] f3, input logic [31:0] a);
    logic e;
    e = f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7 || (w && (f3 == 3'd4 || f3 == 3'd5));
    e = e || (m_size(f3) == 2 && a % 2 != 0) || (m_size(f3) == 4 && a % 4 != 0);
`ifdef LSU_RANGE_CHECK_EN
    e = e || (a >= 32'd1024);
`endif
    return e;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] v;
    int sz;
    sz = m_size(f3);
    v = 0;
    for (int i = 0; i < sz; i++) v = v + (32'(ref_mem[(a + i) % 1024]) << (8 * i));
    if (f3 < 3'd4 && sz < 4 && v[8 * sz - 1]) v = v | (32'hFFFF_FFFF << (8 * sz));
    return v;
  endfunction

  task automatic m_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    for (int i = 0; i < m_size(f3); i++) ref_mem[(a + i) % 1024] = wd[8 * i +: 8];
  endtask

  task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output logic e, output int na, output int nb);
    @(negedge clk);
    req_valid = 1'b1; req_we = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 99; rd = 'x; e = 1'bx; na = 0; nb = 0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (we_a) na++;
      if (we_b) nb++;
      if (resp_valid) begin
        lat = n; rd = resp_rdata; e = resp_err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    total++;
    if ({resp_valid, resp_err, resp_rdata, we_a, we_b, addr_a, addr_b, data_in_a, data_in_b} !== 64'd0) begin
      $display("FAIL reset_outputs got rv=%b err=%b rd=%h wea=%b web=%b aa=%h ab=%h da=%h db=%h want all zero",
               resp_valid, resp_err, resp_rdata, we_a, we_b, addr_a, addr_b, data_in_a, data_in_b);
    end else passed++;
    @(negedge clk) rst = 1'b0;
    #1 total++;
    if (req_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", req_ready); else passed++;
  endtask

  task automatic test_store_load();
    int lat, na, nb;
    logic [31:0] rd;
    logic e;
    logic [2:0] f3s [5] = '{3'd2, 3'd0, 3'd4, 3'd1, 3'd5};
    logic [31:0] as [5] = '{32'h010, 32'h013, 32'h013, 32'h012, 32'h012};
    logic [31:0] xs [5] = '{32'hA1B2C3D4, 32'hFFFFFFA1, 32'h000000A1, 32'hFFFFA1B2, 32'h0000A1B2};
    do_req(1'b1, 3'd2, 32'h010, 32'hA1B2C3D4, lat, rd, e, na, nb);
    m_store(3'd2, 32'h010, 32'hA1B2C3D4);
    total++;
    if ({lat, e, rd, na, nb} !== {32'd3, 1'b0, 32'd0, 32'd2, 32'd2})
      $display("FAIL sw_resp got lat=%0d err=%b rd=%h wea=%0d web=%0d want lat=3 err=0 rd=0 wea=2 web=2", lat, e, rd, na, nb);
    else passed++;
    total++;
    if ({ram[16'h13], ram[16'h12], ram[16'h11], ram[16'h10]} !== 32'hA1B2C3D4)
      $display("FAIL sw_ram got %h%h%h%h want a1b2c3d4", ram[16'h13], ram[16'h12], ram[16'h11], ram[16'h10]);
    else passed++;
    for (int i = 0; i < 5; i++) begin
      do_req(1'b0, f3s[i], as[i], $urandom, lat, rd, e, na, nb);
      total++;
      if ({lat, e, rd} !== {(f3s[i] == 3'd2) ? 32'd3 : 32'd2, 1'b0, xs[i]})
        $display("FAIL load_%0d got lat=%0d err=%b rd=%h want lat=%0d err=0 rd=%h", i, lat, e, rd,
                 (f3s[i] == 3'd2) ? 3 : 2, xs[i]);
      else passed++;
    end
  endtask

  task automatic test_errors();
    int lat, na, nb;
    logic [31:0] rd;
    logic e;
    logic ws [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [2:0] f3s [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd2};
    logic [31:0] as [8] = '{32'h021, 32'h022, 32'h020, 32'h020, 32'h020, 32'h020, 32'h020, 32'h012};
    for (int i = 0; i < 8; i++) begin
      do_req(ws[i], f3s[i], as[i], $urandom, lat, rd, e, na, nb);
      total++;
      if ({lat, e, rd, na + nb} !== {32'd1, 1'b1, 32'd0, 32'd0})
        $display("FAIL err_%0d got lat=%0d err=%b rd=%h we_pulses=%0d want lat=1 err=1 rd=0 we_pulses=0",
                 i, lat, e, rd, na + nb);
      else passed++;
    end
    do_req(1'b0, 3'd2, 32'h020, 0, lat, rd, e, na, nb);
    total++;
    if ({e, rd} !== {1'b0, m_load(3'd2, 32'h020)})
      $display("FAIL err_readback20 got err=%b rd=%h want err=0 rd=%h", e, rd, m_load(3'd2, 32'h020));
    else passed++;
    do_req(1'b0, 3'd2, 32'h010, 0, lat, rd, e, na, nb);
    total++;
    if ({e, rd} !== {1'b0, 32'hA1B2C3D4})
      $display("FAIL err_readback10 got err=%b rd=%h want err=0 rd=a1b2c3d4", e, rd);
    else passed++;
  endtask

  task automatic test_boundary();
    int lat, na, nb;
    logic [31:0] rd, wd;
    logic e;
    logic [31:0] low;
    do_req(1'b1, 3'd0, 32'h3FF, 32'h0000005A, lat, rd, e, na, nb);
    m_store(3'd0, 32'h3FF, 32'h5A);
    total++;
    if ({lat, e, na, nb} !== {32'd2, 1'b0, 32'd1, 32'd0})
      $display("FAIL sb_top got lat=%0d err=%b wea=%0d web=%0d want lat=2 err=0 wea=1 web=0", lat, e, na, nb);
    else passed++;
    do_req(1'b0, 3'd4, 32'h3FF, 0, lat, rd, e, na, nb);
    total++;
    if ({lat, rd} !== {32'd2, 32'h5A}) $display("FAIL lbu_top got lat=%0d rd=%h want lat=2 rd=5a", lat, rd);
    else passed++;
    do_req(1'b0, 3'd2, 32'h3FC, 0, lat, rd, e, na, nb);
    total++;
    if ({lat, e, rd} !== {32'd3, 1'b0, m_load(3'd2, 32'h3FC)})
      $display("FAIL lw_top got lat=%0d err=%b rd=%h want lat=3 err=0 rd=%h", lat, e, rd, m_load(3'd2, 32'h3FC));
    else passed++;
    low = m_load(3'd2, 32'h0);
    wd = $urandom;
    do_req(1'b1, 3'd2, 32'h3FC, wd, lat, rd, e, na, nb);
    m_store(3'd2, 32'h3FC, wd);
    total++;
    if ({ram[3], ram[2], ram[1], ram[0], ram[1023], ram[1022], ram[1021], ram[1020]} !== {low, wd})
      $display("FAIL sw_top_nowrap got low=%h%h%h%h top=%h%h%h%h want low=%h top=%h", ram[3], ram[2], ram[1], ram[0],
               ram[1023], ram[1022], ram[1021], ram[1020], low, wd);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int lat, na, nb, resp_seen;
    logic [31:0] rd;
    logic e;
    logic [7:0] b42, b43;
    b42 = ref_mem[16'h42];
    b43 = ref_mem[16'h43];
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h040; req_wdata = 32'h11223344;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk) rst = 1'b1;
    #1 total++;
    if ({we_a, we_b, resp_valid} !== 3'b000) $display("FAIL rst_mid_we got wea=%b web=%b rv=%b want 000", we_a, we_b, resp_valid);
    else passed++;
    @(negedge clk) rst = 1'b0;
    ref_mem[16'h40] = 8'h44;
    ref_mem[16'h41] = 8'h33;
    resp_seen = 0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (resp_valid) resp_seen++;
    end
    total++;
    if ({resp_seen, req_ready} !== {32'd0, 1'b1}) $display("FAIL rst_mid_resp got resp=%0d ready=%b want resp=0 ready=1", resp_seen, req_ready);
    else passed++;
    do_req(1'b0, 3'd2, 32'h040, 0, lat, rd, e, na, nb);
    total++;
    if (rd !== {b43, b42, 8'h33, 8'h44}) $display("FAIL rst_mid_readback got %h want %h", rd, {b43, b42, 8'h33, 8'h44});
    else passed++;
  endtask

  task automatic test_range();
    int lat, na, nb;
    logic [31:0] rd;
    logic e;
    do_req(1'b0, 3'd2, 32'h400, 0, lat, rd, e, na, nb);
    total++;
`ifdef LSU_RANGE_CHECK_EN
    if ({lat, e, rd} !== {32'd1, 1'b1, 32'd0}) $display("FAIL range got lat=%0d err=%b rd=%h want lat=1 err=1 rd=0", lat, e, rd);
    else passed++;
`else
    if ({lat, e, rd} !== {32'd3, 1'b0, m_load(3'd2, 32'h0)})
      $display("FAIL range_alias got lat=%0d err=%b rd=%h want lat=3 err=0 rd=%h", lat, e, rd, m_load(3'd2, 32'h0));
    else passed++;
`endif
  endtask

  task automatic test_random();
    int lat, na, nb, xl, bad;
    logic [31:0] rd, a, wd, xr;
    logic e, w, xe;
    logic [2:0] f3;
    for (int i = 0; i < 60; i++) begin
      w = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a = $urandom_range(0, 1023);
      if ($urandom_range(0, 3) == 0) a = a + ($urandom_range(1, 15) << 10);
      wd = $urandom;
      xe = m_err(w, f3, a);
      xl = xe ? 1 : (f3 == 3'd2) ? 3 : 2;
      xr = (xe || w) ? 32'd0 : m_load(f3, a);
      do_req(w, f3, a, wd, lat, rd, e, na, nb);
      if (!xe && w) m_store(f3, a, wd);
      total++;
      if ({lat, e, rd} !== {xl, xe, xr})
        $display("FAIL rand_%0d w=%b f3=%0d a=%h got lat=%0d err=%b rd=%h want lat=%0d err=%b rd=%h",
                 i, w, f3, a, lat, e, rd, xl, xe, xr);
      else passed++;
    end
    bad = 0;
    for (int i = 0; i < 1024; i++) if (ram[i] !== ref_mem[i]) bad++;
    total++;
    if (bad != 0) $display("FAIL rand_ram got %0d differing bytes want 0", bad);
    else passed++;
  endtask

  initial begin
    rst = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 0; req_wdata = 0;
    #2 rst = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      pl_en = 1'b1; pl_addr = 10'(i); pl_data = 8'($urandom);
      ref_mem[i] = pl_data;
    end
    @(negedge clk) pl_en = 1'b0;
    test_reset();
    test_store_load();
    test_errors();
    test_boundary();
    test_reset_mid();
    test_range();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1);
  end
endmodule
